// File: rtl/sdram_arbiter_if.sv
// Bundle of the requester-side and ip_sdram-side signals of the SDRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic
// (VDP port, cartridge bus memory path and ip_sdram) that drives it.
interface sdram_arbiter_if;
  // VDP (V9958 clone VRAM port) requester
  logic        vdp_req;
  logic        vdp_wr;
  logic [22:0] vdp_address;
  logic [7:0]  vdp_wdata;
  logic        vdp_ack;
  logic [15:0] vdp_rdata;
  logic        vdp_rdata_en;

  // CPU (cartridge bus memory path) requester
  logic        cpu_req;
  logic        cpu_wr;
  logic [22:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_rdata_en;

  // ip_sdram controller port
  logic        sdram_rd_n;
  logic        sdram_wr_n;
  logic        sdram_busy;
  logic [22:0] sdram_address;
  logic [7:0]  sdram_wdata;
  logic [15:0] sdram_rdata;
  logic        sdram_rdata_en;

  modport slave (
    input  vdp_req, vdp_wr, vdp_address, vdp_wdata,
    output vdp_ack, vdp_rdata, vdp_rdata_en,
    input  cpu_req, cpu_wr, cpu_address, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_rdata_en,
    output sdram_rd_n, sdram_wr_n, sdram_address, sdram_wdata,
    input  sdram_busy, sdram_rdata, sdram_rdata_en
  );

  modport master (
    output vdp_req, vdp_wr, vdp_address, vdp_wdata,
    input  vdp_ack, vdp_rdata, vdp_rdata_en,
    output cpu_req, cpu_wr, cpu_address, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_rdata_en,
    input  sdram_rd_n, sdram_wr_n, sdram_address, sdram_wdata,
    output sdram_busy, sdram_rdata, sdram_rdata_en
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of ip_sdram: VDP has priority, CPU is protected
// from starvation by a VDP streak limiter. One SDRAM operation is in flight
// at a time: grant + command, wait for busy to rise, wait for busy to fall.
module sdram_arbiter #(
  parameter int MAX_VDP_STREAK = 4,
  parameter int BUSY_TIMEOUT   = 7
) (
  input  logic           clk,
  input  logic           n_reset,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_VDP_STREAK);
  localparam logic [3:0] TMO_LAST   = 4'(BUSY_TIMEOUT - 1);

  localparam logic OWNER_VDP = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [22:0] address_q, address_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        vdp_ack_q, vdp_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [15:0] vdp_rdata_q, vdp_rdata_d;
  logic        vdp_rdata_en_q, vdp_rdata_en_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rdata_en_q, cpu_rdata_en_d;
  logic [3:0]  streak_q, streak_d;
  logic [3:0]  tmo_q, tmo_d;

  logic        pick_cpu;
  logic        sel_wr;

  // Arbitration choice and the read/write flavour of the winning request.
  always_comb begin
    pick_cpu = bus.cpu_req && (!bus.vdp_req || (streak_q == STREAK_MAX));
    sel_wr   = pick_cpu ? bus.cpu_wr : bus.vdp_wr;
  end

  // Next-state logic: grant, command pulse, busy handshake and read routing.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wr_d           = wr_q;
    address_d      = address_q;
    wdata_d        = wdata_q;
    rd_n_d         = 1'b1;
    wr_n_d         = 1'b1;
    vdp_ack_d      = 1'b0;
    cpu_ack_d      = 1'b0;
    vdp_rdata_d    = vdp_rdata_q;
    vdp_rdata_en_d = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_rdata_en_d = 1'b0;
    streak_d       = streak_q;
    tmo_d          = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.sdram_busy && (bus.vdp_req || bus.cpu_req)) begin
          state_d = ST_ISSUE;
          wr_d    = sel_wr;
          // The command strobe is registered so it is low exactly while in ST_ISSUE.
          rd_n_d  = sel_wr;
          wr_n_d  = !sel_wr;
          if (pick_cpu) begin
            owner_d   = OWNER_CPU;
            address_d = bus.cpu_address;
            wdata_d   = bus.cpu_wdata;
            cpu_ack_d = 1'b1;
            streak_d  = 4'd0;
          end else begin
            owner_d   = OWNER_VDP;
            address_d = bus.vdp_address;
            wdata_d   = bus.vdp_wdata;
            vdp_ack_d = 1'b1;
            if (!bus.cpu_req) begin
              streak_d = 4'd0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end
      ST_ISSUE: begin
        tmo_d   = 4'd0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.sdram_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // ip_sdram never acknowledged the command; give the slot back.
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.sdram_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) &&
        bus.sdram_rdata_en && !wr_q) begin
      if (owner_q == OWNER_CPU) begin
        cpu_rdata_d    = bus.sdram_rdata;
        cpu_rdata_en_d = 1'b1;
      end else begin
        vdp_rdata_d    = bus.sdram_rdata;
        vdp_rdata_en_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWNER_VDP;
      wr_q           <= 1'b0;
      address_q      <= 23'd0;
      wdata_q        <= 8'd0;
      rd_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      vdp_ack_q      <= 1'b0;
      cpu_ack_q      <= 1'b0;
      vdp_rdata_q    <= 16'd0;
      vdp_rdata_en_q <= 1'b0;
      cpu_rdata_q    <= 16'd0;
      cpu_rdata_en_q <= 1'b0;
      streak_q       <= 4'd0;
      tmo_q          <= 4'd0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wr_q           <= wr_d;
      address_q      <= address_d;
      wdata_q        <= wdata_d;
      rd_n_q         <= rd_n_d;
      wr_n_q         <= wr_n_d;
      vdp_ack_q      <= vdp_ack_d;
      cpu_ack_q      <= cpu_ack_d;
      vdp_rdata_q    <= vdp_rdata_d;
      vdp_rdata_en_q <= vdp_rdata_en_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rdata_en_q <= cpu_rdata_en_d;
      streak_q       <= streak_d;
      tmo_q          <= tmo_d;
    end
  end

  assign bus.sdram_rd_n    = rd_n_q;
  assign bus.sdram_wr_n    = wr_n_q;
  assign bus.sdram_address = address_q;
  assign bus.sdram_wdata   = wdata_q;
  assign bus.vdp_ack       = vdp_ack_q;
  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.vdp_rdata     = vdp_rdata_q;
  assign bus.vdp_rdata_en  = vdp_rdata_en_q;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.cpu_rdata_en  = cpu_rdata_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small ip_sdram behavioural model.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic n_reset = 1'b0;

  sdram_arbiter_if dif();

  sdram_arbiter #(.MAX_VDP_STREAK(4), .BUSY_TIMEOUT(7)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (dif)
  );

  always #5 clk = ~clk;

  // ip_sdram model: busy for 3 cycles after a command, read data one cycle before busy drops
  int          model_cnt   = 0;
  logic        model_busy  = 1'b0;
  logic        model_en    = 1'b0;
  logic        model_read  = 1'b0;
  logic        model_dead  = 1'b0;
  logic        force_busy  = 1'b0;
  logic        stray_en    = 1'b0;
  logic [15:0] model_rdata = 16'h0000;

  assign dif.sdram_busy     = model_busy | force_busy;
  assign dif.sdram_rdata    = model_rdata;
  assign dif.sdram_rdata_en = model_en | stray_en;

  always @(posedge clk) begin
    #1;
    if (model_cnt != 0) begin
      model_cnt = model_cnt - 1;
      model_en  = (model_cnt == 1) && model_read;
      if (model_cnt == 0) model_busy = 1'b0;
    end else if (!model_dead && (dif.sdram_rd_n == 1'b0 || dif.sdram_wr_n == 1'b0)) begin
      model_busy = 1'b1;
      model_cnt  = 3;
      model_read = (dif.sdram_rd_n == 1'b0);
      model_en   = 1'b0;
    end else begin
      model_en = 1'b0;
    end
  end

  // Event monitor: counts pulses and logs grant order
  int          cyc = 0;
  int          vdp_ack_cnt = 0, cpu_ack_cnt = 0, rd_low_cnt = 0, wr_low_cnt = 0;
  int          vdp_en_cnt = 0, cpu_en_cnt = 0, grant_n = 0;
  logic        grant_log [0:63];
  logic        both_low = 1'b0;
  logic [22:0] cmd_addr = 23'd0;
  logic [7:0]  cmd_wdata = 8'd0;

  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (dif.vdp_ack === 1'b1) begin
      vdp_ack_cnt = vdp_ack_cnt + 1;
      if (grant_n < 64) grant_log[grant_n] = 1'b0;
      grant_n = grant_n + 1;
    end
    if (dif.cpu_ack === 1'b1) begin
      cpu_ack_cnt = cpu_ack_cnt + 1;
      if (grant_n < 64) grant_log[grant_n] = 1'b1;
      grant_n = grant_n + 1;
    end
    if (dif.sdram_rd_n === 1'b0) begin
      rd_low_cnt = rd_low_cnt + 1;
      cmd_addr   = dif.sdram_address;
    end
    if (dif.sdram_wr_n === 1'b0) begin
      wr_low_cnt = wr_low_cnt + 1;
      cmd_addr   = dif.sdram_address;
      cmd_wdata  = dif.sdram_wdata;
    end
    if (dif.sdram_rd_n === 1'b0 && dif.sdram_wr_n === 1'b0) both_low = 1'b1;
    if (dif.vdp_rdata_en === 1'b1) vdp_en_cnt = vdp_en_cnt + 1;
    if (dif.cpu_rdata_en === 1'b1) cpu_en_cnt = cpu_en_cnt + 1;
  end

  int compared = 0;
  int mismatched = 0;
  int b_vack, b_cack, b_rd, b_wr, b_ven, b_cen, b_grant;
  int t_a, t_b;
  logic [9:0] seq;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    b_vack = vdp_ack_cnt; b_cack = cpu_ack_cnt;
    b_rd = rd_low_cnt;    b_wr = wr_low_cnt;
    b_ven = vdp_en_cnt;   b_cen = cpu_en_cnt;
    b_grant = grant_n;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v_req, input logic v_wr, input logic [22:0] v_addr,
                               input logic [7:0] v_wd, input logic c_req, input logic c_wr,
                               input logic [22:0] c_addr, input logic [7:0] c_wd);
    dif.vdp_req = v_req; dif.vdp_wr = v_wr; dif.vdp_address = v_addr; dif.vdp_wdata = v_wd;
    dif.cpu_req = c_req; dif.cpu_wr = c_wr; dif.cpu_address = c_addr; dif.cpu_wdata = c_wd;
  endtask

  task automatic waitAck(input logic cpu, input int limit, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((cpu ? dif.cpu_ack : dif.vdp_ack) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    applyStimulus(0, 0, 23'd0, 8'd0, 0, 0, 23'd0, 8'd0);
    n_reset = 1'b0;
    ticks(3);

    // Reset values
    checkOutput("rst_rd_n",     {31'd0, dif.sdram_rd_n}, 32'd1);
    checkOutput("rst_wr_n",     {31'd0, dif.sdram_wr_n}, 32'd1);
    checkOutput("rst_address",  {9'd0, dif.sdram_address}, 32'd0);
    checkOutput("rst_wdata",    {24'd0, dif.sdram_wdata}, 32'd0);
    checkOutput("rst_acks",     {30'd0, dif.vdp_ack, dif.cpu_ack}, 32'd0);
    checkOutput("rst_rdata_en", {30'd0, dif.vdp_rdata_en, dif.cpu_rdata_en}, 32'd0);
    checkOutput("rst_rdata",    {dif.vdp_rdata, dif.cpu_rdata}, 32'd0);
    n_reset = 1'b1;
    ticks(2);

    // VDP read at 0x012345 returning 0xBEEF
    snap();
    model_rdata = 16'hBEEF;
    applyStimulus(1, 0, 23'h012345, 8'h00, 0, 0, 23'd0, 8'd0);
    waitAck(1'b0, 10, "vdp_rd_ack_seen");
    checkOutput("vdp_rd_cmd_with_ack", {31'd0, dif.sdram_rd_n}, 32'd0);
    checkOutput("vdp_rd_address", {9'd0, dif.sdram_address}, 32'h012345);
    dif.vdp_req = 1'b0;
    ticks(10);
    checkOutput("vdp_rd_ack_count", vdp_ack_cnt - b_vack, 32'd1);
    checkOutput("vdp_rd_rd_low", rd_low_cnt - b_rd, 32'd1);
    checkOutput("vdp_rd_wr_low", wr_low_cnt - b_wr, 32'd0);
    checkOutput("vdp_rd_en_count", vdp_en_cnt - b_ven, 32'd1);
    checkOutput("vdp_rd_cpu_en", cpu_en_cnt - b_cen, 32'd0);
    checkOutput("vdp_rd_rdata", {16'd0, dif.vdp_rdata}, 32'hBEEF);

    // CPU write 0x5A to 0x400000
    snap();
    applyStimulus(0, 0, 23'd0, 8'd0, 1, 1, 23'h400000, 8'h5A);
    waitAck(1'b1, 10, "cpu_wr_ack_seen");
    dif.cpu_req = 1'b0;
    ticks(10);
    checkOutput("cpu_wr_ack_count", cpu_ack_cnt - b_cack, 32'd1);
    checkOutput("cpu_wr_wr_low", wr_low_cnt - b_wr, 32'd1);
    checkOutput("cpu_wr_rd_low", rd_low_cnt - b_rd, 32'd0);
    checkOutput("cpu_wr_wdata", {24'd0, cmd_wdata}, 32'h5A);
    checkOutput("cpu_wr_address", {9'd0, cmd_addr}, 32'h400000);
    checkOutput("cpu_wr_no_rdata_en", (vdp_en_cnt - b_ven) + (cpu_en_cnt - b_cen), 32'd0);
    checkOutput("cpu_wr_vdp_rdata_hold", {16'd0, dif.vdp_rdata}, 32'hBEEF);

    // Both requesters held high: expect V,V,V,V,C,V,V,V,V,C
    snap();
    model_rdata = 16'h1111;
    applyStimulus(1, 0, 23'h000010, 8'h00, 1, 0, 23'h000020, 8'h00);
    for (int i = 0; i < 300 && (grant_n - b_grant) < 10; i++) tick();
    applyStimulus(0, 0, 23'd0, 8'd0, 0, 0, 23'd0, 8'd0);
    checkOutput("streak_grant_total", grant_n - b_grant, 32'd10);
    for (int i = 0; i < 10; i++) seq[i] = (b_grant + i < 64) ? grant_log[b_grant + i] : 1'b0;
    checkOutput("streak_sequence", {22'd0, seq}, 32'b10000_10000);
    ticks(10);

    // Busy never rises: WAIT_BUSY lasts 7 cycles, then the pending CPU write is granted
    snap();
    model_dead = 1'b1;
    applyStimulus(1, 0, 23'h000300, 8'h00, 1, 1, 23'h000100, 8'h77);
    waitAck(1'b0, 10, "tmo_vdp_ack_seen");
    t_a = cyc;
    dif.vdp_req = 1'b0;
    waitAck(1'b1, 30, "tmo_cpu_ack_seen");
    t_b = cyc;
    checkOutput("tmo_cpu_wr_cmd", {31'd0, dif.sdram_wr_n}, 32'd0);
    dif.cpu_req = 1'b0;
    checkOutput("tmo_ack_spacing", t_b - t_a, 32'd9);
    ticks(12);
    checkOutput("tmo_no_rdata_en", (vdp_en_cnt - b_ven) + (cpu_en_cnt - b_cen), 32'd0);
    model_dead = 1'b0;

    // Reset during WAIT_DONE of a VDP read swallows the read data
    snap();
    model_rdata = 16'h1234;
    applyStimulus(1, 0, 23'h0000AA, 8'h00, 0, 0, 23'd0, 8'd0);
    waitAck(1'b0, 10, "mid_rst_ack_seen");
    dif.vdp_req = 1'b0;
    ticks(2);
    n_reset = 1'b0;
    tick();
    checkOutput("mid_rst_rdata_en", {30'd0, dif.vdp_rdata_en, dif.cpu_rdata_en}, 32'd0);
    checkOutput("mid_rst_rdata", {dif.vdp_rdata, dif.cpu_rdata}, 32'd0);
    checkOutput("mid_rst_address", {9'd0, dif.sdram_address}, 32'd0);
    checkOutput("mid_rst_strobes", {30'd0, dif.sdram_rd_n, dif.sdram_wr_n}, 32'd3);
    tick();
    n_reset = 1'b1;
    ticks(5);
    checkOutput("mid_rst_no_delivery", vdp_en_cnt - b_ven, 32'd0);

    // Stray rdata_en while idle is ignored
    snap();
    model_rdata = 16'hDEAD;
    stray_en = 1'b1;
    tick();
    stray_en = 1'b0;
    ticks(3);
    checkOutput("stray_no_en", (vdp_en_cnt - b_ven) + (cpu_en_cnt - b_cen), 32'd0);
    checkOutput("stray_rdata_unchanged", {dif.vdp_rdata, dif.cpu_rdata}, 32'd0);

    // Busy held high from reset blocks the grant until it falls
    force_busy = 1'b1;
    applyStimulus(1, 0, 23'h000ABC, 8'h00, 0, 0, 23'd0, 8'd0);
    n_reset = 1'b0;
    ticks(2);
    n_reset = 1'b1;
    snap();
    model_rdata = 16'h4321;
    ticks(8);
    checkOutput("busy_hold_no_ack", vdp_ack_cnt - b_vack, 32'd0);
    force_busy = 1'b0;
    tick();
    checkOutput("busy_fall_ack", {31'd0, dif.vdp_ack}, 32'd1);
    dif.vdp_req = 1'b0;
    ticks(10);
    checkOutput("busy_fall_rdata", {16'd0, dif.vdp_rdata}, 32'h4321);
    checkOutput("never_both_low", {31'd0, both_low}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single ip_sdram controller port between two requesters: the V9958 clone's VRAM port (VDP, high priority) and the MSX cartridge bus memory path (CPU, low priority).
- Sequences exactly one SDRAM operation at a time: grant, command pulse, wait for completion, read-data routing.
- A streak limiter prevents VDP traffic from starving the CPU.
- Sits between the bus/VDP logic and ip_sdram in the top level, all on the 108 MHz clk.

Parameters:
- MAX_VDP_STREAK, 4: maximum consecutive VDP grants while CPU request is pending (range 1..15).
- BUSY_TIMEOUT, 7: cycles to wait for sdram_busy to rise after a command before abandoning the wait (range 2..15).

Ports:
- clk  in  1  system clock, 108 MHz
- n_reset  in  1  synchronous reset, active low
- vdp_req  in  1  VDP request, level, held until vdp_ack
- vdp_wr  in  1  1 = write, 0 = read
- vdp_address  in  23  VDP SDRAM byte address
- vdp_wdata  in  8  VDP write data
- vdp_ack  out  1  one-cycle grant/accept pulse
- vdp_rdata  out  16  read data to VDP
- vdp_rdata_en  out  1  one-cycle valid for vdp_rdata
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_address  in  23  CPU SDRAM byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle grant/accept pulse
- cpu_rdata  out  16  read data to CPU
- cpu_rdata_en  out  1  one-cycle valid for cpu_rdata
- sdram_rd_n  out  1  read command to ip_sdram, active low, one-cycle pulse
- sdram_wr_n  out  1  write command to ip_sdram, active low, one-cycle pulse
- sdram_busy  in  1  ip_sdram busy
- sdram_address  out  23  latched address of current operation
- sdram_wdata  out  8  latched write data of current operation
- sdram_rdata  in  16  ip_sdram read data
- sdram_rdata_en  in  1  ip_sdram read data valid

Behaviour:
- Reset (n_reset = 0 at a clk edge):
  - State goes to ST_IDLE; this also applies mid-operation.
  - sdram_rd_n = sdram_wr_n = 1; sdram_address = 0; sdram_wdata = 0.
  - Both acks = 0, both rdata_en = 0, both rdata = 0.
  - Streak counter = 0; owner = VDP.
- ST_IDLE:
  - Arbitrates only when sdram_busy = 0 and at least one req = 1.
  - Selection:
    - CPU is chosen if cpu_req = 1 and (vdp_req = 0 or streak = MAX_VDP_STREAK).
    - Otherwise VDP is chosen.
  - On selection:
    - Latch owner, wr, address and wdata from the chosen port into the sdram_* registers.
    - Pulse the chosen ack for 1 cycle (registered, asserted the cycle after the sampling edge).
    - Go to ST_ISSUE.
  - A requester must deassert or re-present req the cycle after its ack. A req still high one cycle after ack is a new request.
- ST_ISSUE (1 cycle):
  - Drive sdram_wr_n = 0 if the latched wr = 1, else sdram_rd_n = 0.
  - Clear the timeout counter and go to ST_WAIT_BUSY.
- ST_WAIT_BUSY:
  - sdram_busy = 1 → ST_WAIT_DONE.
  - Timeout counter reaching BUSY_TIMEOUT → ST_IDLE. The command is considered lost; no rdata_en is produced.
- ST_WAIT_DONE:
  - sdram_busy = 0 → ST_IDLE.
  - The next grant can be issued in the cycle following the return to ST_IDLE. Command-to-command minimum is 4 cycles.
- Read routing:
  - When sdram_rdata_en = 1 and state is ST_WAIT_BUSY or ST_WAIT_DONE and the latched op is a read:
    - Register sdram_rdata into owner_rdata.
    - Pulse owner_rdata_en for 1 cycle (1-cycle latency).
  - rdata_en in any other state, or during a write, is ignored.
  - The non-owner rdata output holds its previous value.
- Streak counter (4 bits, saturating at MAX_VDP_STREAK):
  - VDP grant with cpu_req = 1: increment.
  - VDP grant with cpu_req = 0: clear.
  - CPU grant: clear.
- Address and wdata hold stable from grant until the next grant.
- Only one of sdram_rd_n / sdram_wr_n is ever low; both are never low together.
- Requests arriving while not in ST_IDLE are held pending by the requester; no queueing inside the block.

Test Plan:
- Reset then VDP read at 0x012345:
  - vdp_ack pulses once.
  - sdram_rd_n low exactly 1 cycle with sdram_address = 0x012345.
  - Model returns 0xBEEF → vdp_rdata = 0xBEEF with vdp_rdata_en for 1 cycle; cpu_rdata_en stays 0.
- CPU write 0x5A to 0x400000:
  - sdram_wr_n low 1 cycle, sdram_wdata = 0x5A, cpu_ack once.
  - No rdata_en on either port.
- Both requesters held high continuously, MAX_VDP_STREAK = 4 → grant sequence V,V,V,V,C,V,V,V,V,C,…
- Model never raises sdram_busy → ST_WAIT_BUSY exits after 7 cycles and the next pending request is granted.
- Reset and stray data:
  - n_reset = 0 asserted during ST_WAIT_DONE of a read → all outputs return to reset values next cycle; no rdata_en is delivered.
  - Stray sdram_rdata_en while idle → ignored.
- sdram_busy held high from reset with vdp_req = 1 → no grant until busy falls, then grant within 1 cycle.
